// File: rtl/parking_pkg.sv
// parking_pkg: shared gate FSM state type and stats counter width for the parking sensor FSM and gate controller
package parking_pkg;
  typedef enum logic [1:0] {CLOSED, OPEN, GUARD} gate_state_t;
  localparam int STATS_W = 16;
endpackage

// File: rtl/parking_down_timer.sv
// parking_down_timer: 32-bit loadable down-counter that stops at zero
// Ports: clk, rst_n (async, active-low), load/load_val (load wins over counting), zero (count == 0)
module parking_down_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);
  logic [31:0] cnt;
  assign zero = cnt == 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : zero ? cnt : cnt - 32'd1;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: occupancy counter and entry barrier sequencer (CLOSED -> OPEN -> GUARD)
// Ports: clk, rst_n (async, active-low); req_in (level), enter/exit (1-cycle pulses);
//   gate_open (registered), count/full/empty, timeout (1-cycle pulse),
//   err_tailgate/err_range (sticky until reset), total_in/total_out (lifetime counts).
// Macro PARKING_GATE_STATS_EN enables total_in/total_out; otherwise both are tied to 0.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 16,
  parameter int OPEN_CYCLES  = 50_000_000,
  parameter int GUARD_CYCLES = 5_000_000,
  localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_in,
  input  logic               enter,
  input  logic               exit,
  output logic               gate_open,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               timeout,
  output logic               err_tailgate,
  output logic               err_range,
  output logic [STATS_W-1:0] total_in,
  output logic [STATS_W-1:0] total_out
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  gate_state_t state;
  logic load, zero, inc, dec;
  logic [31:0] load_val;
  assign full  = count == CAP;
  assign empty = count == '0;
  assign inc   = enter & ~exit & ~full;
  assign dec   = exit & ~enter & ~empty;
  // One timer serves both phases: loaded on entry to OPEN and again on entry to GUARD.
  assign load     = (state == CLOSED && req_in && !full) || (state == OPEN && enter);
  assign load_val = state == CLOSED ? 32'(OPEN_CYCLES - 1) : 32'(GUARD_CYCLES - 1);
  parking_down_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= CLOSED;
      gate_open <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        CLOSED: if (req_in && !full) begin
          state     <= OPEN;
          gate_open <= 1'b1;
        end
        OPEN: if (enter) begin
          state     <= GUARD;
          gate_open <= 1'b0;
        end else if (zero) begin
          state     <= CLOSED;
          gate_open <= 1'b0;
          timeout   <= 1'b1;
        end
        GUARD: if (zero) state <= CLOSED;
        default: begin
          state     <= CLOSED;
          gate_open <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count        <= '0;
      err_range    <= 1'b0;
      err_tailgate <= 1'b0;
    end else begin
      count        <= count + CNT_W'(inc) - CNT_W'(dec);
      err_range    <= err_range | (enter & ~exit & full) | (exit & ~enter & empty);
      err_tailgate <= err_tailgate | (enter & (state != OPEN));
    end
`ifdef PARKING_GATE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      total_in  <= '0;
      total_out <= '0;
    end else begin
      total_in  <= total_in + STATS_W'(enter);
      total_out <= total_out + STATS_W'(exit);
    end
`else
  assign total_in  = '0;
  assign total_out = '0;
`endif
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed and randomized checks of parking_gate_ctrl against a cycle-count model
module tb_parking_gate_ctrl;
  localparam int CAP = 2;
  localparam int OPN = 4;
  localparam int GRD = 2;
`ifdef PARKING_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_in = 1'b0, enter = 1'b0, exit = 1'b0;
  logic gate_open, full, empty, timeout, err_tailgate, err_range;
  logic [1:0] count;
  logic [15:0] total_in, total_out;
  int checks = 0, errs = 0;
  bit chk_en = 1'b0;
  int m_open, m_guard, m_cnt;
  bit m_to, m_tg, m_rng;
  logic [15:0] m_tin, m_tout;

  parking_gate_ctrl #(.CAPACITY(CAP), .OPEN_CYCLES(OPN), .GUARD_CYCLES(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .enter(enter), .exit(exit),
    .gate_open(gate_open), .count(count), .full(full), .empty(empty), .timeout(timeout),
    .err_tailgate(err_tailgate), .err_range(err_range), .total_in(total_in), .total_out(total_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_guard = 0; m_cnt = 0;
    m_to = 0; m_tg = 0; m_rng = 0;
    m_tin = '0; m_tout = '0;
  endtask

  // Model: m_open / m_guard are cycles of each window still to run (0 = not in that window).
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else begin
      automatic bit was_open = m_open > 0;
      m_to = 0;
      if (m_open > 0) begin
        if (enter) begin m_open = 0; m_guard = GRD; end
        else if (m_open == 1) begin m_open = 0; m_to = 1; end
        else m_open--;
      end else if (m_guard > 0) m_guard--;
      else if (req_in && m_cnt < CAP) m_open = OPN;
      if (enter && !was_open) m_tg = 1;
      if (enter && !exit) begin
        if (m_cnt < CAP) m_cnt++; else m_rng = 1;
      end else if (exit && !enter) begin
        if (m_cnt > 0) m_cnt--; else m_rng = 1;
      end
      m_tin  = m_tin + 16'(enter);
      m_tout = m_tout + 16'(exit);
    end
  end

  always @(negedge clk)
    if (rst_n && chk_en) begin
      chk("gate_open", 32'(gate_open), 32'(m_open > 0));
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == CAP));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("err_tailgate", 32'(err_tailgate), 32'(m_tg));
      chk("err_range", 32'(err_range), 32'(m_rng));
      chk("total_in", 32'(total_in), STATS ? 32'(m_tin) : 32'd0);
      chk("total_out", 32'(total_out), STATS ? 32'(m_tout) : 32'd0);
    end

  task automatic cyc(bit r, bit e, bit x);
    req_in = r; enter = e; exit = x;
    @(negedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst gate_open", 32'(gate_open), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst flags", 32'({timeout, err_tailgate, err_range}), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(0, 0, 1);
    chk("underflow count", 32'(count), 32'd0);
    chk("underflow err_range", 32'(err_range), 32'd1);
    cyc(1, 0, 0);
    chk("open c1", 32'(gate_open), 32'd1);
    cyc(1, 0, 0);
    chk("open c2", 32'(gate_open), 32'd1);
    cyc(1, 1, 0);
    chk("enter closes", 32'(gate_open), 32'd0);
    chk("enter count", 32'(count), 32'd1);
    chk("enter empty", 32'(empty), 32'd0);
    cyc(0, 0, 0);
    chk("guard c2", 32'(gate_open), 32'd0);
    cyc(0, 0, 0);
    chk("after guard", 32'(gate_open), 32'd0);
    cyc(1, 0, 0);
    chk("to open c1", 32'(gate_open), 32'd1);
    for (int i = 2; i <= OPN; i++) begin
      cyc(0, 0, 0);
      chk("to open held", 32'(gate_open), 32'd1);
    end
    cyc(0, 0, 0);
    chk("to closed", 32'(gate_open), 32'd0);
    chk("to pulse", 32'(timeout), 32'd1);
    cyc(0, 0, 0);
    chk("to pulse end", 32'(timeout), 32'd0);
    chk("to count", 32'(count), 32'd1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("second entry count", 32'(count), 32'd2);
    chk("second entry full", 32'(full), 32'd1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0);
      chk("full blocks", 32'(gate_open), 32'd0);
    end
    chk("no tailgate yet", 32'(err_tailgate), 32'd0);
    cyc(0, 0, 1);
    chk("exit count", 32'(count), 32'd1);
    cyc(0, 1, 1);
    chk("both count", 32'(count), 32'd1);
    chk("both total_in", 32'(total_in), STATS ? 32'd3 : 32'd0);
    chk("both total_out", 32'(total_out), STATS ? 32'd3 : 32'd0);
    cyc(0, 1, 0);
    chk("tailgate count", 32'(count), 32'd2);
    chk("tailgate flag", 32'(err_tailgate), 32'd1);
    cyc(0, 1, 0);
    chk("overflow count", 32'(count), 32'd2);
    chk("overflow err_range", 32'(err_range), 32'd1);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    chk("pre-reset open", 32'(gate_open), 32'd1);
    req_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst gate", 32'(gate_open), 32'd0);
    chk("async rst flags", 32'({timeout, err_tailgate, err_range}), 32'd0);
    chk("async rst count", 32'(count), 32'd0);
    chk("async rst empty", 32'(empty), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(2) != 0, $urandom_range(3) == 0, $urandom_range(4) == 0);
    cyc(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Occupancy and barrier-gate controller that sits downstream of the per-lane sensor FSM. It consumes the single-cycle `enter`/`exit` pulses and keeps a saturating occupancy count. It grants entry-gate openings only while space remains, and sequences the barrier through open, hold and guard phases with cycle-accurate timers. Anomalies such as tailgating, underflow and entry timeout are flagged to the supervisory logic.

## Interface
- `CAPACITY`, default 16: number of parking spaces, range 1..255.
- `OPEN_CYCLES`, default 50_000_000: maximum cycles the gate stays open waiting for an `enter` pulse. Minimum 2.
- `GUARD_CYCLES`, default 5_000_000: cycles the gate is held closed after a car passes. Minimum 1.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_in`, input, 1: car waiting at the entry ticket button. Level-sensitive.
- `enter`, input, 1: one-cycle pulse, a car has fully passed the entry sensor pair.
- `exit`, input, 1: one-cycle pulse, a car has fully passed the exit sensor pair.
- `gate_open`, output, 1: barrier open command.
- `count`, output, `CNT_W`: current occupancy, where `CNT_W = $clog2(CAPACITY+1)`.
- `full`, output, 1: `count == CAPACITY`.
- `empty`, output, 1: `count == 0`.
- `timeout`, output, 1: one-cycle pulse when the gate closes without an `enter`.
- `err_tailgate`, output, 1: sticky flag, set when `enter` arrives while the FSM is not OPEN.
- `err_range`, output, 1: sticky flag, set by an overflow or underflow attempt.
- `total_in`, output, 16: lifetime entry count. Present only with the stats feature (see Configuration).
- `total_out`, output, 16: lifetime exit count. Present only with the stats feature.

## Operation
- **Gate FSM states:** CLOSED, OPEN, GUARD.
- **CLOSED:**
  - If `req_in && !full`, go to OPEN and load the timer with `OPEN_CYCLES-1`.
  - Otherwise stay in CLOSED. `req_in` while `full` is ignored and no flag is raised.
- **OPEN:**
  - On `enter`, go to GUARD and load the timer with `GUARD_CYCLES-1`.
  - Else, when the timer reaches 0, go to CLOSED and pulse `timeout` for one cycle.
  - Otherwise decrement the timer.
- **GUARD:** decrement the timer. When it reaches 0, go to CLOSED. `req_in` is ignored in this state.
- **`gate_open`:** equals 1 exactly while the state is OPEN. It is driven from a register, not decoded combinationally from inputs.
- **Occupancy update, evaluated every cycle:**
  - `enter && exit` together: `count` unchanged; both events are still counted by the stats feature.
  - `enter` only: if `count < CAPACITY`, increment. Otherwise hold and set `err_range`.
  - `exit` only: if `count > 0`, decrement. Otherwise hold and set `err_range`.
- **Tailgating:** `enter` in CLOSED or GUARD still updates `count` under the rules above and sets `err_tailgate`.
- **Sticky flags:** `err_tailgate` and `err_range` are cleared only by reset.
- **`full` during OPEN:** if `full` becomes true while in OPEN (for example a tailgater filled the last slot), the gate stays in OPEN until `enter` or timeout.
- **Reset values:** state CLOSED, timer 0, `count` 0, and all outputs 0 except `empty`, which is 1.

## Timing
- `req_in` sampled high at edge N gives `gate_open` high after edge N; it is visible in cycle N+1.
- `enter` at edge N, while in OPEN, gives `gate_open` low after edge N and `count` updated after the same edge.
- The gate is open for at most `OPEN_CYCLES` cycles. `timeout` is asserted in the cycle after the last open cycle, coincident with the first CLOSED cycle.
- GUARD lasts exactly `GUARD_CYCLES` cycles.
- The earliest re-open from CLOSED is one cycle after GUARD ends.
- `full` and `empty` are decoded from the `count` register and have zero latency relative to `count`.
- Asserting `rst_n` low at any time forces the barrier closed asynchronously, including during OPEN or GUARD.

## Configuration
- **Macro:** `PARKING_GATE_STATS_EN`.
- **Defined:**
  - `total_in` increments on every `enter` pulse and `total_out` on every `exit` pulse.
  - Both are 16-bit, wrap from 0xFFFF to 0, and are not limited by the `count` saturation rules.
- **Undefined:** no counter registers are instantiated and both ports are tied to 0.

## Structure
- **Package `parking_pkg`:**
  - `gate_state_t` enum (CLOSED, OPEN, GUARD).
  - Localparam `STATS_W = 16`.
  - Shared by the sensor FSM and this controller.
- **Sub-module `parking_down_timer`:** a 32-bit loadable down-counter with `load`, `load_val` and `zero` signals. It is instantiated once and shared between the OPEN and GUARD phases.

## Test plan
All scenarios use `CAPACITY=2`, `OPEN_CYCLES=4`, `GUARD_CYCLES=2`.
- `req_in`=1 from reset, `enter` pulse 2 cycles after `gate_open` rises -> `gate_open` high for 2 cycles, then low for 2 GUARD cycles, then `count`=1, `empty`=0.
- `req_in` pulsed with no `enter` -> `gate_open` high for exactly 4 cycles, `timeout` pulses once, `count`=0.
- Two complete entries -> `count`=2, `full`=1. A further `req_in` gives no `gate_open` for 20 cycles.
- `exit` pulse with `count`=0 -> `count` stays 0 and `err_range`=1. A third `enter` at `count`=2 -> `count` stays 2 and `err_range` remains 1.
- `enter` and `exit` in the same cycle with `count`=1 -> `count`=1. With stats enabled, `total_in` and `total_out` each increase by 1.
- `enter` while CLOSED -> `err_tailgate`=1 and `count` increments. `rst_n` pulled low while OPEN -> `gate_open`=0 immediately and all flags clear.
